// File: rtl/alu_arbiter_4bit_if.sv
// Request/response bundle shared by the two ALU requesters and the result consumer.
// The slave modport is the arbiter view; the master modport drives requests and acks.
interface alu_arbiter_4bit_if #(
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_op1;
    logic [3:0]       req0_op2;
    logic [2:0]       req0_ctrl;
    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_op1;
    logic [3:0]       req1_op2;
    logic [2:0]       req1_ctrl;
    logic             resp_valid;
    logic             resp_ack;
    logic             resp_id;
    logic [3:0]       resp_out;
    logic             resp_cout;
    logic             busy;
    logic [CNT_W-1:0] gnt_cnt0;
    logic [CNT_W-1:0] gnt_cnt1;

    modport slave (
        input  req0_valid, req0_op1, req0_op2, req0_ctrl,
        input  req1_valid, req1_op1, req1_op2, req1_ctrl,
        input  resp_ack,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_out, resp_cout,
        output busy, gnt_cnt0, gnt_cnt1
    );

    modport master (
        output req0_valid, req0_op1, req0_op2, req0_ctrl,
        output req1_valid, req1_op1, req1_op2, req1_ctrl,
        output resp_ack,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_out, resp_cout,
        input  busy, gnt_cnt0, gnt_cnt1
    );
endinterface

// File: rtl/alu_arbiter_4bit.sv
// Two requesters share one 4-bit ALU through an IDLE/EXEC/RESP FSM with
// round-robin or fixed-priority arbitration and saturating per-requester grant counters.
module alu_arbiter_4bit #(
    parameter bit FAIR_RR = 1'b1,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_4bit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_accept;
    logic             r_last_gnt;

    logic [3:0]       r_op1;
    logic [3:0]       r_op2;
    logic [2:0]       r_ctrl;
    logic             r_id;

    logic             r_resp_valid;
    logic             r_resp_id;
    logic [3:0]       r_resp_out;
    logic             r_resp_cout;
    logic [CNT_W-1:0] r_gnt_cnt0;
    logic [CNT_W-1:0] r_gnt_cnt1;

    logic [3:0]       w_op2_eff;
    logic [4:0]       w_sum;
    logic [3:0]       w_alu_out;
    logic             w_alu_cout;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_gnt0       = 1'b0;
        w_gnt1       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rst_n) begin
                    // r_last_gnt=1 means requester 1 was served last, so 0 wins a tie.
                    if (bus.req0_valid && (!bus.req1_valid || !FAIR_RR || r_last_gnt)) begin
                        w_gnt0 = 1'b1;
                    end else if (bus.req1_valid) begin
                        w_gnt1 = 1'b1;
                    end
                    if (bus.req0_valid || bus.req1_valid) begin
                        w_next_state = S_EXEC;
                    end
                end
            end
            S_EXEC:  w_next_state = S_RESP;
            S_RESP: begin
                if (bus.resp_ack) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_accept = w_gnt0 | w_gnt1;

    // NOTE: operand registers are only read after a capture, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op1  <= w_gnt1 ? bus.req1_op1  : bus.req0_op1;
            r_op2  <= w_gnt1 ? bus.req1_op2  : bus.req0_op2;
            r_ctrl <= w_gnt1 ? bus.req1_ctrl : bus.req0_ctrl;
            r_id   <= w_gnt1;
        end
    end

    // Subtraction reuses the adder as op1 + ~op2 + 1, so carry=1 means no borrow.
    assign w_op2_eff = r_ctrl[0] ? ~r_op2 : r_op2;
    assign w_sum     = {1'b0, r_op1} + {1'b0, w_op2_eff} + {4'b0000, r_ctrl[0]};

    always_comb begin
        w_alu_out  = 4'b0000;
        w_alu_cout = 1'b0;
        if (r_ctrl[2]) begin
            w_alu_out  = w_sum[3:0];
            w_alu_cout = w_sum[4];
        end else begin
            case (r_ctrl[1:0])
                2'b00:   w_alu_out = r_op1 & r_op2;
                2'b01:   w_alu_out = r_op1 | r_op2;
                2'b10:   w_alu_out = ~r_op1;
                default: w_alu_out = r_op1 ^ r_op2;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_gnt   <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_out   <= 4'b0000;
            r_resp_cout  <= 1'b0;
            r_gnt_cnt0   <= '0;
            r_gnt_cnt1   <= '0;
        end else begin
            if (w_accept) begin
                r_last_gnt <= w_gnt1;
            end
            if (w_gnt0 && (r_gnt_cnt0 != '1)) begin
                r_gnt_cnt0 <= r_gnt_cnt0 + CNT_W'(1);
            end
            if (w_gnt1 && (r_gnt_cnt1 != '1)) begin
                r_gnt_cnt1 <= r_gnt_cnt1 + CNT_W'(1);
            end
            if (r_state == S_EXEC) begin
                r_resp_valid <= 1'b1;
                r_resp_id    <= r_id;
                r_resp_out   <= w_alu_out;
                r_resp_cout  <= w_alu_cout;
            end else if ((r_state == S_RESP) && bus.resp_ack) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    assign bus.req0_ready = w_gnt0;
    assign bus.req1_ready = w_gnt1;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_out   = r_resp_out;
    assign bus.resp_cout  = r_resp_cout;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.gnt_cnt0   = r_gnt_cnt0;
    assign bus.gnt_cnt1   = r_gnt_cnt1;

endmodule

// File: doc/alu_arbiter_4bit.md
ALU_ARBITER_4BIT -- requirements
Module: alu_arbiter_4bit

Interface
REQ-001 Parameter: FAIR_RR, 1, 1 = round-robin arbitration; 0 = fixed priority with requester 0 winning.
REQ-002 Parameter: CNT_W, 8, width of the per-requester saturating grant counters.
REQ-003 One clock and one reset: reset is synchronous and active-low (the polarity and synchronicity are fixed).
REQ-004 Port: clk  input  1  clock; all state updates on its rising edge.
REQ-005 Port: rst_n  input  1  synchronous active-low reset.
REQ-006 Port: req0_valid / req1_valid  input  1  requester n presents an operation.
REQ-007 Port: req0_ready / req1_ready  output  1  operation of requester n accepted this cycle.
REQ-008 Port: req0_op1, req0_op2, req1_op1, req1_op2  input  4  operands.
REQ-009 Port: req0_ctrl / req1_ctrl  input  3  ALU control.
- [2]=1: arithmetic; [0]=0 add, [0]=1 subtract.
- [2]=0: logic; [1:0] = 00 AND, 01 OR, 10 NOT op1, 11 XOR.
REQ-010 Port: resp_valid  output  1  result available.
REQ-011 Port: resp_ack  input  1  consumer takes the result.
REQ-012 Port: resp_id  output  1  requester that owns the result.
REQ-013 Port: resp_out  output  4  ALU result.
REQ-014 Port: resp_cout  output  1  carry out.
REQ-015 Port: busy  output  1  high whenever the state is not IDLE.
REQ-016 Port: gnt_cnt0 / gnt_cnt1  output  CNT_W  accepted-operation counters.

Function
REQ-017 The block shall share one 4-bit ALU between the two requesters using a three-state FSM: IDLE, EXEC, RESP.
REQ-018 In IDLE, when at least one valid is high, the block shall assert ready combinationally for the winner only, capture the winner's op1/op2/ctrl/id into registers, and move to EXEC.
REQ-019 Arbitration, FAIR_RR=1, single valid: the valid requester shall win.
REQ-020 Arbitration, FAIR_RR=1, both valid: the requester not granted last shall win; a last-grant pointer updates on every accept.
REQ-021 Arbitration, FAIR_RR=0: requester 0 shall always win when both are valid.
REQ-022 Ready shall be 0 for both requesters in EXEC and RESP; the loser of an arbitration shall keep valid held and is served later, with no request dropped.
REQ-023 In EXEC, the block shall compute on the registered operands, load resp_out/resp_cout/resp_id, set resp_valid, and move to RESP.
REQ-024 Latency: accept at cycle N shall give resp_valid=1 at cycle N+2.
REQ-025 In RESP, resp_valid and all resp_* outputs shall stay stable until resp_ack=1; on that cycle the block shall return to IDLE with resp_valid=0 next cycle.
REQ-026 Minimum issue interval shall be 3 cycles.
REQ-027 resp_ack outside RESP shall be ignored.
REQ-028 Arithmetic shall be 4-bit, wrapping modulo 16; subtract is op1 + ~op2 + 1.
REQ-029 resp_cout shall be the adder carry for arithmetic ops (for subtract, 1 means no borrow) and 0 for logic ops.
REQ-030 gnt_cntN shall increment on each accept of requester N and saturate at 2^CNT_W-1 (no wrap).

Reset
REQ-031 On rst_n=0 at a clock edge:
- state shall go to IDLE;
- resp_valid, resp_out, resp_cout, resp_id, busy, gnt_cnt0 and gnt_cnt1 shall be 0;
- the last-grant pointer shall be set so requester 0 wins the first contention.
REQ-032 Reset in EXEC or RESP shall discard the pending operation; no response shall be issued for it.
REQ-033 ready shall be 0 for both requesters while rst_n=0.

Verification
REQ-034 Add: req0 op1=1001, op2=0101, ctrl=100, resp_ack=1 -> req0_ready=1 at N; resp_valid at N+2 with out=1110, cout=0, id=0.
REQ-035 Subtract: req1 op1=0001, op2=0100, ctrl=101 -> out=1101, cout=0, id=1; op1=0101, op2=0011 -> out=0010, cout=1.
REQ-036 Logic: ctrl 000/001/010/011 with op1=1011, op2=0110 -> out 0010/1111/0100/1101, cout=0.
REQ-037 Contention: both valid continuously after reset, FAIR_RR=1 -> grant order 0,1,0,1; FAIR_RR=0 -> 0,0,0.
REQ-038 Backpressure: resp_ack=0 for 5 cycles -> resp_* stable, both ready=0, busy=1; ack -> IDLE next cycle.
REQ-039 Reset and saturation:
- rst_n=0 during EXEC -> no resp_valid, counters 0;
- 300 req0 accepts with CNT_W=8 -> gnt_cnt0=255.
